// File: rtl/gpio_cfg_sequencer.sv
// gpio_cfg_sequencer: fetches one configuration word per pad (highest pad
// first), shifts each word MSB-first down the mprj_io pad control chain on a
// divided serial clock, then pulses serial_load so all pads update together.
//
// Handshake: start is a level request sampled only in IDLE; once accepted,
// busy stays high until the edge that ends the one-cycle done pulse. A start
// seen while busy is dropped, never queued.
module gpio_cfg_sequencer #(
  parameter int NUM_PADS  = 38,
  parameter int CFG_WIDTH = 13,
  parameter int CLK_DIV   = 4
) (
  input  logic                        clock,
  input  logic                        resetb,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic [$clog2(NUM_PADS)-1:0] cfg_index,
  input  logic [CFG_WIDTH-1:0]        cfg_data,
  output logic                        serial_clock,
  output logic                        serial_data,
  output logic                        serial_load,
  output logic [2:0]                  dbg_state
);

  localparam int IW = $clog2(NUM_PADS);
  localparam int DW = $clog2(CLK_DIV) + 1;
  localparam int BW = $clog2(CFG_WIDTH + 1);

  localparam logic [DW-1:0] DIV_HALF  = DW'(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST  = DW'(2 * CLK_DIV - 1);
  localparam logic [DW-1:0] LOAD_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] FETCH_CAP = DW'(1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(CFG_WIDTH - 1);
  localparam logic [IW-1:0] IDX_TOP   = IW'(NUM_PADS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_SHIFT = 3'd2,
    S_LOAD  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [DW-1:0]         r_div;
  logic [BW-1:0]         r_bit;
  logic [CFG_WIDTH-1:0]  r_shift;
  logic [IW-1:0]         r_index;
  logic                  w_bit_end;
  logic                  w_last_bit;
  logic                  w_capture;

  // End of a bit period is the last cycle of the serial_clock high phase.
  assign w_bit_end  = (r_state == S_SHIFT) && (r_div == DIV_LAST);
  assign w_last_bit = w_bit_end && (r_bit == BIT_LAST);
  // Second FETCH cycle: the registered read of cfg_index is now valid.
  assign w_capture  = (r_state == S_FETCH) && (r_div == FETCH_CAP);

  // State register.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) r_state <= S_IDLE;
    else         r_state <= w_next_state;
  end

  // Next-state decode.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next_state = S_FETCH;
      S_FETCH: if (w_capture) w_next_state = S_SHIFT;
      S_SHIFT: if (w_last_bit) w_next_state = (r_index == '0) ? S_LOAD : S_FETCH;
      S_LOAD:  if (r_div == LOAD_LAST) w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Counters, shift register and pad index; counters restart on every state entry.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_div   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_index <= '0;
    end else begin
      if (w_next_state != r_state)   r_div <= '0;
      else if (w_bit_end)            r_div <= '0;
      else if (r_state != S_IDLE)    r_div <= r_div + DW'(1);

      if (w_next_state != r_state)   r_bit <= '0;
      else if (w_bit_end)            r_bit <= r_bit + BW'(1);

      if (w_capture)                 r_shift <= cfg_data;
      else if (w_bit_end)            r_shift <= {r_shift[CFG_WIDTH-2:0], 1'b0};

      if ((r_state == S_IDLE) && start)          r_index <= IDX_TOP;
      else if (w_last_bit && (r_index != '0))    r_index <= r_index - IW'(1);
      else if (r_state == S_DONE)                r_index <= '0;
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    busy         = (r_state != S_IDLE);
    done         = (r_state == S_DONE);
    cfg_index    = r_index;
    serial_clock = (r_state == S_SHIFT) && (r_div >= DIV_HALF);
    serial_data  = (r_state == S_SHIFT) ? r_shift[CFG_WIDTH-1] : 1'b0;
    serial_load  = (r_state == S_LOAD);
    dbg_state    = r_state;
  end

endmodule

// File: tb/tb_gpio_cfg_sequencer.sv
// Bench for gpio_cfg_sequencer: a CLK_DIV=2 instance with a pad chain model
// and a CLK_DIV=1 instance for the fast-divider corner.
module tb_gpio_cfg_sequencer;

  localparam int NP = 3;
  localparam int CW = 4;
  localparam int CD = 2;
  localparam int EXP_BUSY = NP * (2 + 2 * CD * CW) + CD + 1;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic resetb, start_a, start_b;
  logic busy_a, done_a, sclk_a, sdata_a, load_a;
  logic busy_b, done_b, sclk_b, sdata_b, load_b;
  logic [1:0] idx_a, idx_b;
  logic [3:0] cfg_a, cfg_b;
  logic [2:0] dbg_a, dbg_b;
  logic [3:0] mem [0:3];

  // Registered-read configuration store shared by both instances.
  always @(posedge clock) cfg_a <= mem[idx_a];
  always @(posedge clock) cfg_b <= mem[idx_b];

  gpio_cfg_sequencer #(.NUM_PADS(NP), .CFG_WIDTH(CW), .CLK_DIV(CD)) u_dut_a (
    .clock(clock), .resetb(resetb), .start(start_a), .busy(busy_a), .done(done_a),
    .cfg_index(idx_a), .cfg_data(cfg_a), .serial_clock(sclk_a), .serial_data(sdata_a),
    .serial_load(load_a), .dbg_state(dbg_a));

  gpio_cfg_sequencer #(.NUM_PADS(NP), .CFG_WIDTH(CW), .CLK_DIV(1)) u_dut_b (
    .clock(clock), .resetb(resetb), .start(start_b), .busy(busy_b), .done(done_b),
    .cfg_index(idx_b), .cfg_data(cfg_b), .serial_clock(sclk_b), .serial_data(sdata_b),
    .serial_load(load_b), .dbg_state(dbg_b));

  // ---------------- pad chain reference ----------------
  // The chain is one NP*CW shift register fed at bit 0; pad k owns slice k.
  logic [NP*CW-1:0] chain, pads;
  always @(posedge sclk_a) chain <= {chain[NP*CW-2:0], sdata_a};
  always @(posedge clock) if (load_a) pads <= chain;

  // ---------------- monitor A ----------------
  int m_busy, m_done, m_load, m_rises, m_stab, m_since, m_gap;
  logic [11:0] m_bits;
  logic [7:0]  m_seq;
  logic [1:0]  m_last;
  logic p_sclk, p_sdata, p_busy, p_load;

  always @(negedge clock) begin
    if (!resetb) begin
      p_sclk <= 1'b0; p_sdata <= 1'b0; p_busy <= 1'b0; p_load <= 1'b0;
    end else begin
      p_sclk <= sclk_a; p_sdata <= sdata_a; p_busy <= busy_a; p_load <= load_a;
      if (busy_a && !p_busy) begin
        m_busy <= 1; m_done <= 0; m_load <= 0; m_rises <= 0; m_bits <= '0;
        m_stab <= 0; m_since <= 0; m_gap <= -1;
        m_seq <= {6'b0, idx_a}; m_last <= idx_a;
      end else begin
        if (busy_a) m_busy <= m_busy + 1;
        if (done_a) m_done <= m_done + 1;
        if (load_a) m_load <= m_load + 1;
        if (sclk_a && !p_sclk) begin
          m_rises <= m_rises + 1;
          m_bits  <= {m_bits[10:0], sdata_a};
          if (sdata_a != p_sdata) m_stab <= m_stab + 1;
          m_since <= 0;
        end else begin
          m_since <= m_since + 1;
        end
        if (load_a && !p_load) m_gap <= m_since + 1;
        if (busy_a && (idx_a != m_last)) begin
          m_seq  <= {m_seq[5:0], idx_a};
          m_last <= idx_a;
        end
      end
    end
  end

  // ---------------- monitor B (CLK_DIV=1) ----------------
  int b_busy, b_rises, b_stab, b_hh;
  logic [11:0] b_bits;
  logic q_sclk, q_sdata, q_busy;

  always @(negedge clock) begin
    if (!resetb) begin
      q_sclk <= 1'b0; q_sdata <= 1'b0; q_busy <= 1'b0;
    end else begin
      q_sclk <= sclk_b; q_sdata <= sdata_b; q_busy <= busy_b;
      if (busy_b && !q_busy) begin
        b_busy <= 1; b_rises <= 0; b_stab <= 0; b_hh <= 0; b_bits <= '0;
      end else begin
        if (busy_b) b_busy <= b_busy + 1;
        if (sclk_b && q_sclk) b_hh <= b_hh + 1;
        if (sclk_b && !q_sclk) begin
          b_rises <= b_rises + 1;
          b_bits  <= {b_bits[10:0], sdata_b};
          if (sdata_b != q_sdata) b_stab <= b_stab + 1;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_mem(input logic [3:0] w0, input logic [3:0] w1, input logic [3:0] w2);
    mem[0] = w0; mem[1] = w1; mem[2] = w2; mem[3] = 4'h0;
  endtask

  // Waits for done (bounded); optionally pulses start again at cycle extra_at.
  task automatic wait_done_a(input int extra_at, input string name);
    bit ok;
    ok = 0;
    for (int c = 1; c <= 200 && !ok; c++) begin
      @(posedge clock); #1;
      if (c == extra_at)     start_a = 1'b1;
      if (c == extra_at + 1) start_a = 1'b0;
      if (done_a) ok = 1;
    end
    check({name, "_timeout"}, 32'(ok), 32'd1);
    repeat (2) @(posedge clock);
    #1;
  endtask

  task automatic pulse_start_a();
    @(posedge clock); #1 start_a = 1'b1;
    @(posedge clock); #1 start_a = 1'b0;
  endtask

  task automatic check_xfer_a(input string name, input logic [11:0] exp_bits, input int exp_busy);
    check({name, "_bits"},  32'(m_bits),  32'(exp_bits));
    check({name, "_busy"},  32'(m_busy),  32'(exp_busy));
    check({name, "_done"},  32'(m_done),  32'd1);
    check({name, "_load"},  32'(m_load),  32'(CD));
    check({name, "_rises"}, 32'(m_rises), 32'(NP * CW));
    check({name, "_stab"},  32'(m_stab),  32'd0);
    check({name, "_idx"},   32'(m_seq),   32'h24);
    check({name, "_gap"},   32'(m_gap >= CD), 32'd1);
    check({name, "_pads"},  32'(pads),    32'(exp_bits));
  endtask

  typedef struct {
    logic [3:0]  w0, w1, w2;
    int          extra;
    logic [11:0] exp_bits;
    int          exp_busy;
  } vec_t;

  vec_t vecs [4];

  initial begin
    #500000;
    $display("FAIL watchdog: got no_finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] r0, r1, r2;
    logic [11:0] old_pads;
    int g;
    bit ok;

    vecs[0] = '{4'hA, 4'h5, 4'hC, -10, 12'hC5A, 57};
    vecs[1] = '{4'hA, 4'h5, 4'hC,  20, 12'hC5A, 57};
    vecs[2] = '{4'hF, 4'h0, 4'h1, -10, 12'h10F, 57};
    vecs[3] = '{4'h3, 4'h9, 4'h6,  20, 12'h693, 57};

    resetb = 1'b0; start_a = 1'b0; start_b = 1'b0;
    set_mem(4'h0, 4'h0, 4'h0);
    #12;
    check("reset_a", 32'({busy_a, done_a, idx_a, sclk_a, sdata_a, load_a}), 32'd0);
    check("reset_b", 32'({busy_b, done_b, idx_b, sclk_b, sdata_b, load_b}), 32'd0);
    @(posedge clock); #1 resetb = 1'b1;
    repeat (2) @(posedge clock);

    // Table-driven transfers, some with an ignored start at cycle 20.
    for (int i = 0; i < 4; i++) begin
      set_mem(vecs[i].w0, vecs[i].w1, vecs[i].w2);
      pulse_start_a();
      wait_done_a(vecs[i].extra, $sformatf("vec%0d", i));
      check_xfer_a($sformatf("vec%0d", i), vecs[i].exp_bits, vecs[i].exp_busy);
    end

    // Random words against the chain model: pad k must hold word k.
    for (int i = 0; i < 5; i++) begin
      r0 = 4'($urandom_range(0, 15));
      r1 = 4'($urandom_range(0, 15));
      r2 = 4'($urandom_range(0, 15));
      set_mem(r0, r1, r2);
      pulse_start_a();
      wait_done_a(($urandom_range(0, 1) == 1) ? 20 : -10, $sformatf("rnd%0d", i));
      check_xfer_a($sformatf("rnd%0d", i), {r2, r1, r0}, EXP_BUSY);
    end

    // Reset mid-shift: no load, pads keep old contents, then a clean rerun.
    old_pads = pads;
    set_mem(~old_pads[3:0], ~old_pads[7:4], ~old_pads[11:8]);
    pulse_start_a();
    repeat (29) @(posedge clock);
    #1 resetb = 1'b0;
    #1;
    check("midrst_outs", 32'({busy_a, done_a, idx_a, sclk_a, sdata_a, load_a}), 32'd0);
    repeat (3) @(posedge clock);
    #1 resetb = 1'b1;
    repeat (5) @(posedge clock);
    #1;
    check("midrst_noload", 32'(m_load), 32'd0);
    check("midrst_pads", 32'(pads), 32'(old_pads));
    pulse_start_a();
    wait_done_a(-10, "after_rst");
    check_xfer_a("after_rst", ~old_pads, EXP_BUSY);

    // Back-to-back with start held high: exactly one IDLE cycle between.
    set_mem(4'hA, 4'h5, 4'hC);
    @(posedge clock); #1 start_a = 1'b1;
    ok = 0;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(posedge clock); #1;
      if (done_a) ok = 1;
    end
    check("b2b_first_timeout", 32'(ok), 32'd1);
    g = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clock); #1;
      if (busy_a) break;
      g++;
    end
    check("b2b_gap", 32'(g), 32'd1);
    start_a = 1'b0;
    wait_done_a(-10, "b2b");
    check_xfer_a("b2b", 12'hC5A, 57);

    // CLK_DIV=1 corner.
    set_mem(4'hA, 4'h5, 4'hC);
    @(posedge clock); #1 start_b = 1'b1;
    @(posedge clock); #1 start_b = 1'b0;
    ok = 0;
    for (int c = 0; c < 100 && !ok; c++) begin
      @(posedge clock); #1;
      if (done_b) ok = 1;
    end
    check("div1_timeout", 32'(ok), 32'd1);
    repeat (2) @(posedge clock);
    #1;
    check("div1_busy",  32'(b_busy),  32'd32);
    check("div1_rises", 32'(b_rises), 32'd12);
    check("div1_bits",  32'(b_bits),  32'h0C5A);
    check("div1_stab",  32'(b_stab),  32'd0);
    check("div1_alt",   32'(b_hh),    32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/gpio_cfg_sequencer.md
# gpio_cfg_sequencer

Serial configuration sequencer for the user-area GPIO pad control chain (mprj_io). On a start request it reads one configuration word per pad from the housekeeping configuration store, shifts all words MSB-first down the daisy-chained pad control blocks on a divided serial clock, then pulses a load strobe so every pad adopts its new mode together. It sits in housekeeping between the configuration register file and the `serial_clock`/`serial_data`/`serial_load` chain that runs along the padframe.

## Interface
- `NUM_PADS`, 38: number of pad control blocks in the chain; must be ≥2.
- `CFG_WIDTH`, 13: bits per pad configuration word.
- `CLK_DIV`, 4: `clock` cycles per serial_clock phase; must be ≥1.
- `clock` in 1: system clock; all logic on the rising edge.
- `resetb` in 1: asynchronous active-low reset.
- `start` in 1: request a full chain transfer; sampled only in IDLE.
- `busy` out 1: high from the cycle after start is accepted until done.
- `done` out 1: one-cycle pulse on completion.
- `cfg_index` out $clog2(NUM_PADS): pad index being fetched.
- `cfg_data` in CFG_WIDTH: configuration word for `cfg_index`; registered read, valid 1 cycle after `cfg_index` changes.
- `serial_clock` out 1: chain shift clock; pads shift on its rising edge.
- `serial_data` out 1: chain data.
- `serial_load` out 1: chain load strobe, active high.

## Operation
- Reset values: `busy`=0, `done`=0, `cfg_index`=0, `serial_clock`=0, `serial_data`=0, `serial_load`=0, FSM=IDLE.
- **IDLE.** On `start`=1, set `cfg_index`=NUM_PADS-1 and go to FETCH.
- **FETCH (2 cycles).** Cycle 1 waits for the registered read. On cycle 2, capture `cfg_data` into the shift register, clear the bit counter, and go to SHIFT.
- **SHIFT.**
  - Each bit takes 2·CLK_DIV cycles: `serial_clock` low for CLK_DIV, then high for CLK_DIV.
  - `serial_data` = shift_reg[CFG_WIDTH-1] is updated at the first cycle of the low phase. It is stable for the whole low phase and the rising edge.
  - At the end of the high phase, shift left by 1 and increment the bit counter.
  - After CFG_WIDTH bits:
    - If `cfg_index`≠0, decrement it and return to FETCH.
    - If `cfg_index`=0, go to LOAD.
- Pad NUM_PADS-1 is shifted first, so after the last bit pad k holds word k.
- **LOAD.** `serial_clock`=0 and `serial_data`=0. `serial_load`=1 for CLK_DIV cycles, then go to DONE.
- **DONE (1 cycle).** `done`=1. `busy` deasserts at the same edge that ends this state. Then return to IDLE; `cfg_index` returns to 0.
- `serial_clock` is 0 in IDLE, FETCH, LOAD and DONE.
- `start` while busy is ignored and is not queued.
- `start` held high across DONE starts a new transfer on the first IDLE cycle.
- Reset mid-transfer:
  - All outputs return to reset values immediately.
  - `serial_load` is never asserted for a partial transfer, so pads keep their previously loaded configuration. Partial chain contents are overwritten by the next full transfer.
- Divider counter width is $clog2(CLK_DIV)+1. The bit counter is $clog2(CFG_WIDTH+1) bits. Both counters clear on every state entry.

## Timing
- `start` sampled high at edge T0: `busy`=1 and `cfg_index`=NUM_PADS-1 after T0.
- Total busy length is NUM_PADS·(2 + 2·CLK_DIV·CFG_WIDTH) + CLK_DIV + 1 cycles.
- `done` is high during the last busy cycle.
- With the defaults this is 38·106 + 4 + 1 = 4033 cycles.
- serial_clock frequency = f_clock / (2·CLK_DIV).
- Setup: data is stable for CLK_DIV cycles before each serial_clock rise. Hold: data is stable for CLK_DIV cycles after each rise.
- `serial_load` rises at least CLK_DIV cycles after the final serial_clock rise.

## Test plan
Benches use NUM_PADS=3, CFG_WIDTH=4, CLK_DIV=2 unless stated.
- **Basic transfer.**
  - Stimulus: model a 3-entry register file {0:4'hA, 1:4'h5, 2:4'hC}; pulse `start`.
  - Required response: 12 serial_clock rises, sampling bits 1100 0101 1010. Then a 2-cycle `serial_load` pulse. `busy` is high exactly 57 cycles, and `done` pulses once in the last of them. `cfg_index` sequence is 2, 1, 0.
- **Chain model check.**
  - Stimulus: connect a 3×4-bit shift-register chain with load latches; write random words and start.
  - Required response: latched pad words equal the register file after `done`.
- **Start while busy.**
  - Stimulus: pulse `start` again at cycle 20 of a transfer.
  - Required response: `busy` length is still 57 and `done` pulses only once.
- **Reset mid-shift.**
  - Stimulus: assert `resetb`=0 at cycle 30 of a transfer.
  - Required response: all outputs are 0 within the same cycle and `serial_load` never rises. Pad latches keep their prior values. A later `start` completes normally.
- **CLK_DIV=1 corner.**
  - Stimulus: rerun the basic transfer with CLK_DIV=1.
  - Required response: serial_clock alternates every cycle during SHIFT and data is unchanged at each rise. `busy` lasts 3·(2+8)+1+1 = 32 cycles.
- **Back-to-back.**
  - Stimulus: hold `start`=1 continuously.
  - Required response: consecutive transfers separated by exactly one IDLE cycle (`busy` low for 1 cycle), and each transfer is bit-identical to the basic case.
